// File: rtl/audio_sample_scheduler_if.sv
// Receiver-side and output-side signals of the audio sample scheduler.
// The master drives enable/rx_*/clear_flags; the slave (scheduler) drives the rest.
interface audio_sample_scheduler_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             enable;
    logic [15:0]      rx_data;
    logic             rx_valid;
    logic             clear_flags;
    logic             rx_active;
    logic [15:0]      sample_out;
    logic             sample_strobe;
    logic [LVL_W-1:0] fifo_level;
    logic             underrun;
    logic             overflow;
    logic [1:0]       state_out;

    modport master (
        output enable, rx_data, rx_valid, clear_flags,
        input  rx_active, sample_out, sample_strobe, fifo_level, underrun, overflow, state_out
    );

    modport slave (
        input  enable, rx_data, rx_valid, clear_flags,
        output rx_active, sample_out, sample_strobe, fifo_level, underrun, overflow, state_out
    );
endinterface

// File: rtl/audio_sample_scheduler.sv
// Buffers receiver samples in a small FIFO and releases them at a fixed rate,
// handling prefill, underrun and overflow so the output stream is steady.
//
//   state   | meaning
//   IDLE    | receiver gated off, FIFO flushed, no output
//   PREFILL | receiver active, waiting for FILL_START samples
//   PLAY    | one sample popped every DIV cycles
module audio_sample_scheduler #(
    parameter int CLK_HZ     = 25_000_000,
    parameter int SAMPLE_HZ  = 48_000,
    parameter int FIFO_DEPTH = 8,
    parameter int FILL_START = 4
) (
    input  logic                       clock_max,
    input  logic                       reset,
    audio_sample_scheduler_if.slave    bus
);
    localparam int DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] FILL_LVL  = LVL_W'(FILL_START);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_PLAY    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_rx_active;
    logic [CNT_W-1:0] r_tick;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [15:0]      r_mem [FIFO_DEPTH];
    logic [15:0]      r_pop_data;
    logic             r_pop_pend;
    logic [15:0]      r_sample_out;
    logic             r_sample_strobe;
    logic             r_underrun;
    logic             r_overflow;

    logic w_tick, w_empty, w_full, w_pop, w_underrun_evt;
    logic w_accepting, w_push, w_overflow_evt, w_flush;

    // Dropping enable discards a tick landing in the same cycle.
    assign w_tick         = (r_state == ST_PLAY) && (r_tick == TICK_LAST) && bus.enable;
    assign w_empty        = (r_level == '0);
    assign w_full         = (r_level == FULL_LVL);
    assign w_pop          = w_tick && !w_empty;
    assign w_underrun_evt = w_tick && w_empty;
    assign w_accepting    = (r_state != ST_IDLE) && bus.enable;
    assign w_push         = w_accepting && bus.rx_valid && (!w_full || w_pop);
    assign w_overflow_evt = w_accepting && bus.rx_valid && w_full && !w_pop;
    assign w_flush        = (r_state == ST_IDLE) || !bus.enable;

    always_ff @(posedge clock_max or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!bus.enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_nxt = ST_PREFILL;
                ST_PREFILL: if (r_level >= FILL_LVL) w_state_nxt = ST_PLAY;
                ST_PLAY:    if (w_underrun_evt) w_state_nxt = ST_PREFILL;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rx_active = 1'b0;
        case (r_state)
            ST_PREFILL, ST_PLAY: w_rx_active = 1'b1;
            default:             w_rx_active = 1'b0;
        endcase
    end

    always_ff @(posedge clock_max or posedge reset) begin
        if (reset)                             r_tick <= '0;
        else if (r_state == ST_PLAY && bus.enable)
            r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + CNT_W'(1);
        else                                   r_tick <= '0;
    end

    // Read-first storage: a write to the head slot during a pop returns the old value.
    always_ff @(posedge clock_max) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.rx_data;
    end

    always_ff @(posedge clock_max or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_pop_data <= '0;
            r_pop_pend <= 1'b0;
        end else begin
            r_pop_pend <= w_pop;
            if (w_pop) r_pop_data <= r_mem[r_rd_ptr];
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LVL_W'(1);
                    2'b01:   r_level <= r_level - LVL_W'(1);
                    default: r_level <= r_level;
                endcase
            end
        end
    end

    always_ff @(posedge clock_max or posedge reset) begin
        if (reset) begin
            r_sample_out    <= '0;
            r_sample_strobe <= 1'b0;
        end else if (!bus.enable) begin
            r_sample_out    <= '0;
            r_sample_strobe <= 1'b0;
        end else begin
            r_sample_strobe <= r_pop_pend;
            if (r_pop_pend) r_sample_out <= r_pop_data;
        end
    end

    // A set event in the same cycle as clear_flags keeps the flag high.
    always_ff @(posedge clock_max or posedge reset) begin
        if (reset) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_underrun_evt)       r_underrun <= 1'b1;
            else if (bus.clear_flags) r_underrun <= 1'b0;
            if (w_overflow_evt)       r_overflow <= 1'b1;
            else if (bus.clear_flags) r_overflow <= 1'b0;
        end
    end

    assign bus.rx_active     = w_rx_active;
    assign bus.sample_out    = r_sample_out;
    assign bus.sample_strobe = r_sample_strobe;
    assign bus.fifo_level    = r_level;
    assign bus.underrun      = r_underrun;
    assign bus.overflow      = r_overflow;
    assign bus.state_out     = r_state;
endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Directed bench for audio_sample_scheduler with DIV=10, depth 4, prefill 2.
// Inputs change and outputs are sampled on the falling edge of clock_max.
module tb_audio_sample_scheduler;
    logic clock_max = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] cap_val [8];
    int          cap_t   [8];
    int          cap_n;
    bit          cap_to;

    always #5 clock_max = ~clock_max;

    audio_sample_scheduler_if #(.FIFO_DEPTH(4)) bus ();

    audio_sample_scheduler #(
        .CLK_HZ(1000), .SAMPLE_HZ(100), .FIFO_DEPTH(4), .FILL_START(2)
    ) dut (
        .clock_max(clock_max),
        .reset(reset),
        .bus(bus)
    );

    task automatic write_sample(input logic [15:0] d);
        bus.rx_data  = d;
        bus.rx_valid = 1'b1;
        @(negedge clock_max);
        bus.rx_valid = 1'b0;
    endtask

    // Records strobed samples and their cycle index until the FSM falls back to PREFILL.
    task automatic collect_until_prefill();
        cap_n  = 0;
        cap_to = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clock_max);
            if (bus.sample_strobe === 1'b1) begin
                if (cap_n < 8) begin
                    cap_val[cap_n] = bus.sample_out;
                    cap_t[cap_n]   = c;
                end
                cap_n++;
            end
            if (bus.state_out === 2'd1) begin
                cap_to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0; bus.clear_flags = 1'b0;
        repeat (2) @(negedge clock_max);
        checks++; if (bus.state_out !== 2'd0)      begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_out); end
        checks++; if (bus.rx_active !== 1'b0)      begin errors++; $display("FAIL reset_rx_active: got %b expected 0", bus.rx_active); end
        checks++; if (bus.sample_out !== 16'h0)    begin errors++; $display("FAIL reset_sample_out: got %h expected 0000", bus.sample_out); end
        checks++; if (bus.sample_strobe !== 1'b0)  begin errors++; $display("FAIL reset_strobe: got %b expected 0", bus.sample_strobe); end
        checks++; if (bus.fifo_level !== 3'd0)     begin errors++; $display("FAIL reset_level: got %0d expected 0", bus.fifo_level); end
        checks++; if (bus.underrun !== 1'b0 || bus.overflow !== 1'b0)
            begin errors++; $display("FAIL reset_flags: got u=%b o=%b expected 0 0", bus.underrun, bus.overflow); end
        reset = 1'b0;
        @(negedge clock_max);
    endtask

    task automatic test_play_underrun();
        logic exp_stb;
        bus.enable = 1'b1;
        @(negedge clock_max);
        checks++; if (bus.state_out !== 2'd1) begin errors++; $display("FAIL enter_prefill: got %0d expected 1", bus.state_out); end
        write_sample(16'h1111);
        write_sample(16'h2222);
        checks++; if (bus.state_out !== 2'd1 || bus.fifo_level !== 3'd2)
            begin errors++; $display("FAIL prefill_level: got st=%0d lvl=%0d expected st=1 lvl=2", bus.state_out, bus.fifo_level); end
        @(negedge clock_max);
        checks++; if (bus.state_out !== 2'd2) begin errors++; $display("FAIL enter_play: got %0d expected 2", bus.state_out); end
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock_max);
            exp_stb = (k == 11) || (k == 21);
            checks++; if (bus.sample_strobe !== exp_stb)
                begin errors++; $display("FAIL play_strobe cycle %0d: got %b expected %b", k, bus.sample_strobe, exp_stb); end
            checks++; if (bus.rx_active !== 1'b1)
                begin errors++; $display("FAIL play_rx_active cycle %0d: got %b expected 1", k, bus.rx_active); end
            if (k == 11) begin
                checks++; if (bus.sample_out !== 16'h1111) begin errors++; $display("FAIL first_sample: got %h expected 1111", bus.sample_out); end
            end
            if (k == 21) begin
                checks++; if (bus.sample_out !== 16'h2222) begin errors++; $display("FAIL second_sample: got %h expected 2222", bus.sample_out); end
            end
        end
        checks++; if (bus.underrun !== 1'b1)       begin errors++; $display("FAIL underrun_set: got %b expected 1", bus.underrun); end
        checks++; if (bus.state_out !== 2'd1)      begin errors++; $display("FAIL underrun_state: got %0d expected 1", bus.state_out); end
        checks++; if (bus.sample_out !== 16'h2222) begin errors++; $display("FAIL underrun_hold: got %h expected 2222", bus.sample_out); end
        bus.clear_flags = 1'b1;
        @(negedge clock_max);
        bus.clear_flags = 1'b0;
        checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b expected 0", bus.underrun); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) write_sample(16'hA0 + 16'(i));
        checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d expected 4", bus.fifo_level); end
        bus.clear_flags = 1'b1;
        write_sample(16'hA4);
        bus.clear_flags = 1'b0;
        checks++; if (bus.overflow !== 1'b1)   begin errors++; $display("FAIL overflow_set: got %b expected 1", bus.overflow); end
        checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL overflow_level: got %0d expected 4", bus.fifo_level); end
        collect_until_prefill();
        checks++; if (cap_to) begin errors++; $display("FAIL ovf_drain_timeout: got state %0d expected 1", bus.state_out); end
        checks++; if (cap_n !== 4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", cap_n); end
        for (int i = 0; i < 4 && i < cap_n; i++) begin
            checks++; if (cap_val[i] !== 16'hA0 + 16'(i))
                begin errors++; $display("FAIL ovf_sample %0d: got %h expected %h", i, cap_val[i], 16'hA0 + 16'(i)); end
            if (i > 0) begin
                checks++; if (cap_t[i] - cap_t[i-1] !== 10)
                    begin errors++; $display("FAIL strobe_spacing %0d: got %0d expected 10", i, cap_t[i] - cap_t[i-1]); end
            end
        end
        bus.clear_flags = 1'b1;
        @(negedge clock_max);
        bus.clear_flags = 1'b0;
        checks++; if (bus.overflow !== 1'b0 || bus.underrun !== 1'b0)
            begin errors++; $display("FAIL flags_clear: got u=%b o=%b expected 0 0", bus.underrun, bus.overflow); end
    endtask

    task automatic test_full_write_pop();
        logic [15:0] exp_seq [5];
        exp_seq = '{16'hC0, 16'hC1, 16'hC2, 16'hC3, 16'hB0};
        for (int i = 0; i < 4; i++) write_sample(16'hC0 + 16'(i));
        repeat (8) @(negedge clock_max);
        write_sample(16'hB0);
        checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL fullpop_level: got %0d expected 4", bus.fifo_level); end
        checks++; if (bus.overflow !== 1'b0)   begin errors++; $display("FAIL fullpop_overflow: got %b expected 0", bus.overflow); end
        collect_until_prefill();
        checks++; if (cap_to) begin errors++; $display("FAIL fullpop_timeout: got state %0d expected 1", bus.state_out); end
        checks++; if (cap_n !== 5) begin errors++; $display("FAIL fullpop_count: got %0d expected 5", cap_n); end
        for (int i = 0; i < 5 && i < cap_n; i++) begin
            checks++; if (cap_val[i] !== exp_seq[i])
                begin errors++; $display("FAIL fullpop_sample %0d: got %h expected %h", i, cap_val[i], exp_seq[i]); end
        end
    endtask

    task automatic test_enable_drop_tick();
        write_sample(16'hD0);
        write_sample(16'hD1);
        @(negedge clock_max);
        checks++; if (bus.state_out !== 2'd2) begin errors++; $display("FAIL drop_play: got %0d expected 2", bus.state_out); end
        repeat (9) @(negedge clock_max);
        checks++; if (bus.sample_out !== 16'hB0) begin errors++; $display("FAIL drop_pre_sample: got %h expected 00b0", bus.sample_out); end
        bus.enable = 1'b0;
        @(negedge clock_max);
        checks++; if (bus.sample_strobe !== 1'b0) begin errors++; $display("FAIL drop_strobe: got %b expected 0", bus.sample_strobe); end
        checks++; if (bus.state_out !== 2'd0)     begin errors++; $display("FAIL drop_state: got %0d expected 0", bus.state_out); end
        checks++; if (bus.sample_out !== 16'h0)   begin errors++; $display("FAIL drop_sample: got %h expected 0000", bus.sample_out); end
        checks++; if (bus.rx_active !== 1'b0)     begin errors++; $display("FAIL drop_rx_active: got %b expected 0", bus.rx_active); end
        checks++; if (bus.fifo_level !== 3'd0)    begin errors++; $display("FAIL drop_level: got %0d expected 0", bus.fifo_level); end
        @(negedge clock_max);
        checks++; if (bus.sample_strobe !== 1'b0) begin errors++; $display("FAIL drop_late_strobe: got %b expected 0", bus.sample_strobe); end
    endtask

    task automatic test_reset_mid_play();
        bus.enable = 1'b1;
        @(negedge clock_max);
        for (int i = 0; i < 5; i++) write_sample(16'hE0 + 16'(i));
        repeat (9) @(negedge clock_max);
        checks++; if (bus.sample_strobe !== 1'b1 || bus.sample_out !== 16'hE0)
            begin errors++; $display("FAIL pre_reset_strobe: got stb=%b data=%h expected 1 00e0", bus.sample_strobe, bus.sample_out); end
        checks++; if (bus.fifo_level !== 3'd3 || bus.overflow !== 1'b1)
            begin errors++; $display("FAIL pre_reset_state: got lvl=%0d o=%b expected 3 1", bus.fifo_level, bus.overflow); end
        reset = 1'b1;
        #1;
        checks++; if (bus.state_out !== 2'd0 || bus.rx_active !== 1'b0)
            begin errors++; $display("FAIL mid_reset_fsm: got st=%0d act=%b expected 0 0", bus.state_out, bus.rx_active); end
        checks++; if (bus.sample_out !== 16'h0 || bus.sample_strobe !== 1'b0)
            begin errors++; $display("FAIL mid_reset_out: got data=%h stb=%b expected 0000 0", bus.sample_out, bus.sample_strobe); end
        checks++; if (bus.fifo_level !== 3'd0 || bus.underrun !== 1'b0 || bus.overflow !== 1'b0)
            begin errors++; $display("FAIL mid_reset_lvl_flags: got lvl=%0d u=%b o=%b expected 0 0 0", bus.fifo_level, bus.underrun, bus.overflow); end
        bus.enable = 1'b0;
        @(negedge clock_max);
        reset = 1'b0;
        @(negedge clock_max);
        checks++; if (bus.state_out !== 2'd0) begin errors++; $display("FAIL post_reset_state: got %0d expected 0", bus.state_out); end
    endtask

    initial begin
        test_reset();
        test_play_underrun();
        test_overflow();
        test_full_write_pop();
        test_enable_drop_tick();
        test_reset_mid_play();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
